// File: rtl/event_pulse_driver.sv
// Stretches single-cycle trig events into ON_CYCLES-high / GAP_CYCLES-low output pulses.
// Define EVENT_PULSE_QUEUE_EN to queue up to 15 requests that arrive while busy.
module event_pulse_driver #(
   parameter int unsigned ON_CYCLES  = 100000,
   parameter int unsigned GAP_CYCLES = 100000,
   parameter int unsigned CNT_W      = 17
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       trig,
   output logic       out_level,
   output logic       busy,
   output logic [3:0] pend_cnt,
   output logic       drop
);

   typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             gap_end;
   logic             busy_trig;

   assign gap_end   = (state == GAP) && (cnt == GAP_LAST);
   assign busy_trig = (state != IDLE) && trig;

`ifdef EVENT_PULSE_QUEUE_EN
   logic next_pulse;
   // A trig on the last GAP cycle is served by the next pulse straight away.
   assign next_pulse = (pend_cnt != 4'd0) || trig;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         out_level <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (trig) begin
                  state     <= ON;
                  cnt       <= '0;
                  out_level <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            ON: begin
               if (cnt == ON_LAST) begin
                  state     <= GAP;
                  cnt       <= '0;
                  out_level <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               if (gap_end) begin
                  cnt <= '0;
`ifdef EVENT_PULSE_QUEUE_EN
                  if (next_pulse) begin
                     state     <= ON;
                     out_level <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
`else
                  state <= IDLE;
                  busy  <= 1'b0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               out_level <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef EVENT_PULSE_QUEUE_EN
   // At GAP end a trig cancels the decrement, so the count holds and nothing is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_cnt <= '0;
         drop     <= 1'b0;
      end else begin
         drop <= 1'b0;
         if (busy_trig) begin
            if (!gap_end) begin
               if (pend_cnt == 4'd15) drop <= 1'b1;
               else                   pend_cnt <= pend_cnt + 4'd1;
            end
         end else if (gap_end && (pend_cnt != 4'd0)) begin
            pend_cnt <= pend_cnt - 4'd1;
         end
      end
   end
`else
   assign pend_cnt = '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) drop <= 1'b0;
      else          drop <= busy_trig;
   end
`endif

endmodule
